// File: rtl/theta_slice_engine.sv
// Slice-serial theta mixing pass over a 64 x 25-bit slice memory (read-modify-write in place).
// Optional pass signature register and port enabled by defining THETA_SIG_EN.
module theta_slice_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] mem_line,
    output logic [5:0]  mem_addr,
    output logic        wr_en,
    output logic [24:0] write_value,
    output logic        busy,
    output logic        done
`ifdef THETA_SIG_EN
    ,
    output logic [24:0] sig
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [5:0]  z_q, z_d;
    logic [4:0]  prev_par_q, prev_par_d;
    logic [4:0]  col_par_s;
    logic [4:0]  mix_s;

    // Column parity: bit x is the XOR of the five row bits 5*y + x.
    function automatic logic [4:0] col_parity(input logic [24:0] slice);
        col_parity = slice[4:0] ^ slice[9:5] ^ slice[14:10] ^ slice[19:15] ^ slice[24:20];
    endfunction

    // Mix vector: d[x] = cur[(x+4)%5] ^ prev[(x+1)%5], done as two 5-bit rotations.
    function automatic logic [4:0] theta_mix(input logic [4:0] cur, input logic [4:0] prev);
        theta_mix = {cur[3:0], cur[4]} ^ {prev[0], prev[4:1]};
    endfunction

    assign col_par_s = col_parity(mem_line);
    assign mix_s     = theta_mix(col_par_s, prev_par_q);

    // Next-state, slice counter and carried parity.
    always_comb begin
        state_d    = state_q;
        z_d        = z_q;
        prev_par_d = prev_par_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRE;
                    z_d     = 6'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                state_d    = S_RUN;
                prev_par_d = col_par_s;
            end
            S_RUN: begin
                prev_par_d = col_par_s;
                z_d        = z_q + 6'd1;
                if (z_q == 6'd63) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            z_q        <= 6'd0;
            prev_par_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            z_q        <= z_d;
            prev_par_q <= prev_par_d;
        end
    end

    // Outputs are pure decodes of state/z, except the mixed write data.
    always_comb begin
        mem_addr    = 6'd0;
        wr_en       = 1'b0;
        write_value = 25'd0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        if (state_q == S_RUN) begin
            mem_addr    = z_q;
            wr_en       = 1'b1;
            write_value = mem_line ^ {5{mix_s}};
        end else if (state_q == S_PRE) begin
            mem_addr = 6'd63;
        end else begin
            mem_addr = 6'd0;
        end
    end

`ifdef THETA_SIG_EN
    logic [24:0] sig_q, sig_d;

    // Signature: cleared in PRE, accumulates every written slice.
    always_comb begin
        sig_d = sig_q;
        if (state_q == S_PRE) begin
            sig_d = 25'd0;
        end else if (state_q == S_RUN) begin
            sig_d = sig_q ^ write_value;
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 25'd0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

endmodule

// File: tb/tb_theta_slice_engine.sv
// Bench for theta_slice_engine: behavioural slice memory, reference theta model and write scoreboard.
module tb_theta_slice_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [24:0] mem_line;
    logic [5:0]  mem_addr;
    logic        wr_en;
    logic [24:0] write_value;
    logic        busy;
    logic        done;
`ifdef THETA_SIG_EN
    logic [24:0] sig;
`endif

    logic [24:0] mem  [64];
    logic [24:0] snap [64];
    logic [24:0] orig [64];
    logic [24:0] exp_sig;

    typedef struct {
        logic [5:0]  a;
        logic [24:0] v;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [5:0]  seed_a;
        logic [24:0] seed_v;
        logic [5:0]  a1;
        logic [24:0] e1;
        logic [5:0]  a2;
        logic [24:0] e2;
        logic [24:0] e_sig;
        int          e_nonzero;
    } vec_t;
    vec_t vecs[4];

    int checks = 0;
    int failures = 0;

    theta_slice_engine dut (
        .clk(clk), .rst(rst), .start(start), .mem_line(mem_line),
        .mem_addr(mem_addr), .wr_en(wr_en), .write_value(write_value),
        .busy(busy), .done(done)
`ifdef THETA_SIG_EN
        , .sig(sig)
`endif
    );

    always #5 clk = ~clk;

    assign mem_line = mem[mem_addr];

    always @(posedge clk) begin
        if (wr_en) mem[mem_addr] <= write_value;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every write is popped and compared against the model.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {26'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {26'd0, mem_addr}, {26'd0, e.a});
                chk("wr_value", {7'd0, write_value}, {7'd0, e.v});
            end
        end
    end

    function automatic logic [24:0] ref_theta(input logic [24:0] cur, input logic [24:0] prv);
        logic [4:0]  c;
        logic [4:0]  p;
        logic [24:0] r;
        for (int x = 0; x < 5; x++) begin
            c[x] = 1'b0;
            p[x] = 1'b0;
            for (int y = 0; y < 5; y++) begin
                c[x] ^= cur[5*y+x];
                p[x] ^= prv[5*y+x];
            end
        end
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[5*y+x] = cur[5*y+x] ^ c[(x+4)%5] ^ p[(x+1)%5];
        return r;
    endfunction

    // One modelled pass over snap: pushes expected writes, updates snap and exp_sig.
    task automatic model_pass();
        logic [24:0] nxt [64];
        wr_t w;
        exp_sig = 25'd0;
        for (int z = 0; z < 64; z++) begin
            nxt[z] = ref_theta(snap[z], snap[(z+63)%64]);
            exp_sig ^= nxt[z];
            w.a = z[5:0];
            w.v = nxt[z];
            exp_q.push_back(w);
        end
        for (int z = 0; z < 64; z++) snap[z] = nxt[z];
    endtask

    task automatic load_fill(input logic [5:0] a, input logic [24:0] v, input bit rnd);
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            if (rnd) mem[i] <= 25'($urandom);
            else     mem[i] <= (i[5:0] == a) ? v : 25'd0;
        end
        #1;
    endtask

    task automatic run_pass(input string nm);
        int cyc;
        for (int i = 0; i < 64; i++) snap[i] = mem[i];
        model_pass();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        chk({nm, "_busy_pre"}, {31'd0, busy}, 32'd1);
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_done_cycle"}, cyc, 32'd66);
        chk({nm, "_queue_empty"}, exp_q.size(), 32'd0);
`ifdef THETA_SIG_EN
        chk({nm, "_sig"}, {7'd0, sig}, {7'd0, exp_sig});
`endif
        @(posedge clk);
        #1;
        chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int nz;
        int bad;
        int dcnt;
        int dcyc[4];

        vecs[0] = '{6'd0,  25'h0000000, 6'd0, 25'h0000000, 6'd1,  25'h0000000, 25'h0000000, 0};
        vecs[1] = '{6'd0,  25'h0000001, 6'd0, 25'h0210843, 6'd1,  25'h1084210, 25'h1294A53, 2};
        vecs[2] = '{6'd63, 25'h0000001, 6'd0, 25'h1084210, 6'd63, 25'h0210843, 25'h1294A53, 2};
        vecs[3] = '{6'd5,  25'h1FFFFFF, 6'd5, 25'h0000000, 6'd6,  25'h1FFFFFF, 25'h1FFFFFF, 1};

        for (int i = 0; i < 64; i++) mem[i] = 25'd0;
        #3;
        chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_write_value", {7'd0, write_value}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
`ifdef THETA_SIG_EN
        chk("rst_sig", {7'd0, sig}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Directed single-slice patterns.
        for (int t = 0; t < 4; t++) begin
            load_fill(vecs[t].seed_a, vecs[t].seed_v, 1'b0);
            run_pass($sformatf("vec%0d", t));
            chk($sformatf("vec%0d_slice_a1", t), {7'd0, mem[vecs[t].a1]}, {7'd0, vecs[t].e1});
            chk($sformatf("vec%0d_slice_a2", t), {7'd0, mem[vecs[t].a2]}, {7'd0, vecs[t].e2});
            nz = 0;
            for (int i = 0; i < 64; i++) if (mem[i] != 25'd0) nz++;
            chk($sformatf("vec%0d_nonzero", t), nz, vecs[t].e_nonzero);
`ifdef THETA_SIG_EN
            chk($sformatf("vec%0d_sig_const", t), {7'd0, sig}, {7'd0, vecs[t].e_sig});
`endif
        end

        // start held high: back-to-back passes, one done every 67 cycles.
        load_fill(6'd0, 25'd0, 1'b1);
        for (int i = 0; i < 64; i++) snap[i] = mem[i];
        for (int p = 0; p < 3; p++) model_pass();
        dcnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (dcnt < 4) dcyc[dcnt] = c;
                dcnt++;
            end
        end
        start = 1'b0;
        chk("hold_done_count", dcnt, 32'd3);
        chk("hold_first_done", dcyc[0], 32'd66);
        chk("hold_spacing1", dcyc[1] - dcyc[0], 32'd67);
        chk("hold_spacing2", dcyc[2] - dcyc[1], 32'd67);
        chk("hold_queue_empty", exp_q.size(), 32'd0);
`ifdef THETA_SIG_EN
        chk("hold_sig", {7'd0, sig}, {7'd0, exp_sig});
`endif
        repeat (2) @(posedge clk);

        // Reset while z=10: abort with slices 0..9 already mixed.
        load_fill(6'd0, 25'd0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            snap[i] = mem[i];
            orig[i] = mem[i];
        end
        model_pass();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("abort_addr_before", {26'd0, mem_addr}, 32'd10);
        rst = 1'b1;
        #1;
        chk("abort_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
        chk("abort_write_value", {7'd0, write_value}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
`ifdef THETA_SIG_EN
        chk("abort_sig", {7'd0, sig}, 32'd0);
`endif
        chk("abort_pending_writes", exp_q.size(), 32'd54);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (i < 10 && mem[i] !== snap[i]) bad++;
            if (i >= 10 && mem[i] !== orig[i]) bad++;
        end
        chk("abort_mem_contents", bad, 32'd0);
        run_pass("after_abort");

        // Random memory, 20 consecutive passes against the model.
        load_fill(6'd0, 25'd0, 1'b1);
        for (int p = 0; p < 20; p++) run_pass($sformatf("rand%0d", p));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/theta_slice_engine.md
# theta_slice_engine

Slice-serial theta (column-parity mixing) stage of the matrix encoder. Runs immediately upstream of the rotate stage over the same 64-entry × 25-bit slice memory. It reads each slice once, XORs every column with the parities of its two neighbouring columns, and writes the result back in place, so the memory holds theta-mixed slices when rotate starts. One pass takes 66 cycles and is triggered by a start pulse from the top-level controller.

## Interface
Parameters: none. Geometry is fixed at 5×5 lanes and 64 slices.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse to begin a pass; sampled only in IDLE
- mem_line  in  25  read data for `mem_addr`, combinational (same-cycle) memory read
- mem_addr  out  6  slice index being read and written
- wr_en  out  1  write strobe; memory writes `write_value` to `mem_addr` on the next rising edge
- write_value  out  25  mixed slice
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
- done  out  1  one-cycle pulse at the end of a pass
- sig  out  25  pass signature; present only with `THETA_SIG_EN`

## Operation
- Bit mapping: slice bit i = 5*y + x, with x,y in 0..4. Column parity C_z[x] = XOR over y of slice_z[5y+x].
- D_z[x] = C_z[(x+4)%5] ^ C_{(z+63)%64}[(x+1)%5]. Output slice bit 5y+x = slice_z[5y+x] ^ D_z[x].
- States:
  - IDLE → PRE on start.
  - PRE (1 cycle): mem_addr=63, wr_en=0; latch prev_par ← C_63. This supplies the wrap-around for z=0 before slice 63 is overwritten.
  - RUN (64 cycles): mem_addr=z, wr_en=1, write_value computed combinationally from mem_line and prev_par. At each edge prev_par ← C_z and z increments. After z=63, go to DONE.
  - DONE (1 cycle): done=1, wr_en=0 → IDLE.
- z is a 6-bit counter that is cleared on PRE entry. z=63 is the terminal count.
- start is ignored in PRE, RUN and DONE. No queuing.
- Reset values:
  - state=IDLE, z=0, prev_par=0
  - mem_addr=0, wr_en=0, write_value=0, busy=0, done=0, sig=0
  - In IDLE and DONE, mem_addr=0 and write_value=0.
- Reset mid-pass aborts immediately. Slices already written stay modified. No partial done is issued.

## Timing
- Start sampled high in IDLE at edge 0:
  - PRE in cycle 1
  - RUN cycles 2..65 (slice z written at end of cycle z+2)
  - done high in cycle 66
  - IDLE in cycle 67
- A start asserted in the done cycle is ignored. A start asserted in cycle 67 (IDLE) is accepted.
- Write path is single-cycle read-modify-write. The memory must return the pre-write value in the same cycle.
- Every output is registered or decoded from state and z only, except write_value, which is combinational from mem_line.

## Configuration
- `THETA_SIG_EN` defined:
  - 25-bit register sig is cleared in PRE.
  - On each RUN cycle, sig ← sig ^ write_value.
  - sig holds its value after done until the next PRE or reset.
- Not defined: port sig and its logic are absent. All other behaviour is identical.

## Test plan
- All-zero memory, start → 64 writes of 0x0000000 to addresses 0..63; done high exactly 66 cycles after start; sig=0.
- Only slice0 = 0x0000001 → slice0 = 0x0210843, slice1 = 0x1084210, all others 0; sig=0x1294A53.
- Wrap-around: only slice63 = 0x0000001 → slice0 = 0x1084210, slice63 = 0x0210843, others 0.
- start held high for 200 cycles → exactly one done every 67 cycles. No restarts during busy.
- Assert rst in RUN at z=10 → all outputs 0 same cycle. Slices 0..9 modified, 10..63 untouched. Next start performs a clean full pass.
- Random memory, 20 passes → each write_value matches a reference theta model bit-exactly; sig equals the XOR of all 64 outputs.
